posit_mult_sched_es3: RTL and testbench
=======================================

Name: posit_mult_sched_es3

Overview:
- Shares one fixed-latency ES3 posit multiplier pipeline (raw sum-value × posit operand → raw product value) among NREQ requesters.
- Round-robin arbitration issues at most one operation per cycle. Each issued operation carries a requester tag through a tag shadow pipe. Results are buffered in a response FIFO and returned to the owning requester.
- Credit-based issue: the multiplier has no back-pressure, so every in-flight result is guaranteed a FIFO slot. Sits between the accumulator/dot-product front-ends and the multiplier.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TAGW, 2, tag width, clog2(NREQ)
- IN1_W, 42, serialized sum-value operand width
- IN2_W, 32, serialized posit operand width
- RES_W, 76, serialized product width
- MULT_LAT, 4, multiplier start→done latency in cycles
- RSP_DEPTH, 8, response FIFO entries; must be ≥ MULT_LAT

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  one-hot grant; handshake = valid&ready
- req_in1  in  NREQ*IN1_W  packed operand 1; requester i occupies [i*IN1_W +: IN1_W]
- req_in2  in  NREQ*IN2_W  packed operand 2
- mult_in1  out  IN1_W  multiplier operand 1
- mult_in2  out  IN2_W  multiplier operand 2
- mult_start  out  1  multiplier start pulse
- mult_result  in  RES_W  multiplier result
- mult_done  in  1  multiplier done
- rsp_valid  out  NREQ  one-hot; set for the tag owner of the FIFO head
- rsp_ready  in  NREQ  per-requester accept
- rsp_result  out  RES_W  FIFO head result
- busy  out  1  in-flight count ≠ 0 or FIFO not empty
- tag_err  out  1  sticky: mult_done with no tag expected

Behaviour:
- Reset values: req_ready=0, mult_start=0, mult_in1/2=0, rsp_valid=0, rsp_result=0, busy=0, tag_err=0. Round-robin pointer=0; tag pipe valids=0; FIFO empty; inflight=0.
- Credit: avail = RSP_DEPTH − fifo_count − inflight. Issue is allowed only when avail>0.
- Arbitration (combinational): when avail>0, grant the first requester with req_valid set, searching from rr_ptr upward and wrapping. req_ready = one-hot grant; otherwise all zeros.
- Pointer update: on a grant to requester g, rr_ptr ← (g+1) mod NREQ. With no grant the pointer holds.
- Issue register: on a grant, the next cycle has mult_start=1, mult_in1/2 = the granted operands, and tag = g. With no grant, mult_start=0 and operands hold their previous values.
- Tag pipe: a shift register MULT_LAT deep of {valid,tag}, loaded in step with mult_start. Its output is aligned with mult_done.
- inflight: +1 on mult_start, −1 on mult_done. Both in the same cycle → unchanged.
- On mult_done: push {tag_pipe_out.tag, mult_result} into the FIFO.
  - If tag_pipe_out.valid=0: set tag_err, drop the push, inflight unchanged.
  - A push while full cannot occur by construction. Assert it in simulation.
- Response side: when not empty, rsp_valid[head.tag]=1 and rsp_result=head.result. Pop on rsp_valid&rsp_ready of the same index. rsp_ready of any other index is ignored.
- Simultaneous push and pop: FIFO count unchanged, entry order preserved.
- Empty FIFO: push in one cycle → rsp_valid asserts the next cycle. No bypass.
- Latency: req handshake at cycle t → mult_start at t+1 → mult_done at t+1+MULT_LAT → rsp_valid at t+2+MULT_LAT.
- A requester blocked at the FIFO head stalls all responses (in-order return). Issue continues until credits run out.
- Reset mid-operation: all state clears immediately. Results still in the multiplier that arrive after reset raise tag_err. Integration must reset the multiplier start pipe alongside this block.

Optional Feature:
- Macro POSIT_MULT_SCHED_PERF_EN.
- Defined: adds outputs perf_issued[31:0] (count of mult_start) and perf_stall[31:0] (cycles with any req_valid but no grant). Both are wrapping counters, reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single requester: req_valid[2]=1 for one op with in1=42'h1_0000_0001, in2=32'h4000_0000. Expect req_ready=4'b0100, mult_start 1 cycle later, rsp_valid=4'b0100 exactly MULT_LAT+2 cycles after the handshake, rsp_result = the model multiplier output.
- Fairness: all four requesters hold req_valid, rsp_ready all 1. Expect grant order 0,1,2,3,0,… with one grant per cycle for 16 cycles, and responses returned in the same order.
- Back-pressure: rsp_ready=0 with continuous requests. Expect exactly RSP_DEPTH=8 grants, then req_ready=0. Release rsp_ready → one new grant per pop.
- Simultaneous push/pop: FIFO holds 3 entries, mult_done coincides with a pop. Expect count stays 3 and busy=1.
- Spurious done: pulse mult_done with the tag pipe empty. Expect tag_err=1 (sticky until rst_n), no rsp_valid.
- Reset mid-flight: assert rst_n=0 two cycles after an issue. Expect all outputs 0 asynchronously and inflight=0 after release.

Source files
------------

// File: rtl/posit_mult_sched_es3.sv
// posit_mult_sched_es3: round-robin, credit-based scheduler sharing one fixed-latency ES3 posit multiplier.
// Define POSIT_MULT_SCHED_PERF_EN to add the perf_issued/perf_stall counters.
module posit_mult_sched_es3 #(
   parameter int NREQ      = 4,
   parameter int TAGW      = 2,
   parameter int IN1_W     = 42,
   parameter int IN2_W     = 32,
   parameter int RES_W     = 76,
   parameter int MULT_LAT  = 4,
   parameter int RSP_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*IN1_W-1:0]   req_in1,
   input  logic [NREQ*IN2_W-1:0]   req_in2,
   output logic [IN1_W-1:0]        mult_in1,
   output logic [IN2_W-1:0]        mult_in2,
   output logic                    mult_start,
   input  logic [RES_W-1:0]        mult_result,
   input  logic                    mult_done,
   output logic [NREQ-1:0]         rsp_valid,
   input  logic [NREQ-1:0]         rsp_ready,
   output logic [RES_W-1:0]        rsp_result,
   output logic                    busy,
   output logic                    tag_err
`ifdef POSIT_MULT_SCHED_PERF_EN
   ,
   output logic [31:0]             perf_issued,
   output logic [31:0]             perf_stall
`endif
);
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);

   logic [TAGW-1:0]                rr_q, tag_q, g, head_tag;
   logic                           hit, run_q, start_q, err_q, credit, push, pop, empty;
   logic [IN1_W-1:0]               in1_q;
   logic [IN2_W-1:0]               in2_q;
   logic [MULT_LAT-1:0]            pv_q;
   logic [MULT_LAT-1:0][TAGW-1:0]  pt_q;
   logic [CW-1:0]                  infl_q, cnt_q;
   logic [PW-1:0]                  wp_q, rp_q;
   logic [TAGW+RES_W-1:0]          mem [RSP_DEPTH];

   // start_q counts as a credit too: it is issued but not yet in infl_q
   assign credit = run_q && (int'(cnt_q) + int'(infl_q) + int'(start_q) < RSP_DEPTH);

   always_comb begin
      hit = 1'b0;
      g   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!hit && credit && req_valid[(int'(rr_q) + k) % NREQ]) begin
            hit = 1'b1;
            g   = TAGW'((int'(rr_q) + k) % NREQ);
         end
      end
   end

   assign req_ready  = hit ? NREQ'(1) << g : '0;
   assign empty      = cnt_q == '0;
   assign head_tag   = mem[rp_q][TAGW+RES_W-1:RES_W];
   assign push       = mult_done && pv_q[MULT_LAT-1];
   assign pop        = !empty && rsp_ready[head_tag];
   assign rsp_valid  = empty ? '0 : NREQ'(1) << head_tag;
   assign rsp_result = empty ? '0 : mem[rp_q][RES_W-1:0];
   assign busy       = infl_q != '0 || !empty;
   assign tag_err    = err_q;
   assign mult_start = start_q;
   assign mult_in1   = in1_q;
   assign mult_in2   = in2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q   <= 1'b0;
         start_q <= 1'b0;
         rr_q    <= '0;
         tag_q   <= '0;
         in1_q   <= '0;
         in2_q   <= '0;
         pv_q    <= '0;
         pt_q    <= '0;
         infl_q  <= '0;
         cnt_q   <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         run_q   <= 1'b1;
         start_q <= hit;
         if (hit) begin
            rr_q  <= (g == TAGW'(NREQ - 1)) ? '0 : g + 1'b1;
            tag_q <= g;
            in1_q <= req_in1[g*IN1_W +: IN1_W];
            in2_q <= req_in2[g*IN2_W +: IN2_W];
         end
         pv_q[0] <= start_q;
         pt_q[0] <= tag_q;
         for (int k = 1; k < MULT_LAT; k++) begin
            pv_q[k] <= pv_q[k-1];
            pt_q[k] <= pt_q[k-1];
         end
         infl_q <= infl_q + CW'(start_q) - CW'(push);
         cnt_q  <= cnt_q + CW'(push) - CW'(pop);
         if (push) wp_q <= (wp_q == PW'(RSP_DEPTH - 1)) ? '0 : wp_q + 1'b1;
         if (pop) rp_q <= (rp_q == PW'(RSP_DEPTH - 1)) ? '0 : rp_q + 1'b1;
         if (mult_done && !pv_q[MULT_LAT-1]) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp_q] <= {pt_q[MULT_LAT-1], mult_result};
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) assert (cnt_q != CW'(RSP_DEPTH));
   end

`ifdef POSIT_MULT_SCHED_PERF_EN
   logic [31:0] iss_q, stall_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_q   <= '0;
         stall_q <= '0;
      end else begin
         iss_q   <= iss_q + 32'(start_q);
         stall_q <= stall_q + 32'(|req_valid && !hit);
      end
   end
   assign perf_issued = iss_q;
   assign perf_stall  = stall_q;
`endif
endmodule

// File: tb/tb_posit_mult_sched_es3.sv
// tb_posit_mult_sched_es3: directed bench with a 4-cycle behavioural multiplier model.
module tb_posit_mult_sched_es3;
   localparam int NREQ = 4, IN1_W = 42, IN2_W = 32, RES_W = 76, MULT_LAT = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]       req_valid = '0, rsp_ready = '0, req_ready, rsp_valid;
   logic [NREQ*IN1_W-1:0] req_in1 = '0;
   logic [NREQ*IN2_W-1:0] req_in2 = '0;
   logic [IN1_W-1:0]      mult_in1;
   logic [IN2_W-1:0]      mult_in2;
   logic                  mult_start, mult_done, busy, tag_err, spur = 1'b0;
   logic [RES_W-1:0]      mult_result, rsp_result;
   logic [MULT_LAT-1:0]   sr = '0;
   logic [RES_W-1:0]      rs [MULT_LAT];
   int checks = 0, errors = 0;

   posit_mult_sched_es3 dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_in1(req_in1), .req_in2(req_in2), .mult_in1(mult_in1), .mult_in2(mult_in2),
      .mult_start(mult_start), .mult_result(mult_result), .mult_done(mult_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .busy(busy), .tag_err(tag_err)
   );

   // multiplier model: done and product appear MULT_LAT cycles after start
   always @(posedge clk) begin
      sr <= {sr[MULT_LAT-2:0], mult_start};
      rs[0] <= RES_W'(mult_in1) * RES_W'(mult_in2);
      for (int k = 1; k < MULT_LAT; k++) rs[k] <= rs[k-1];
   end
   assign mult_done   = sr[MULT_LAT-1] | spur;
   assign mult_result = rs[MULT_LAT-1];

   task automatic set_ops();
      for (int i = 0; i < NREQ; i++) begin
         req_in1[i*IN1_W +: IN1_W] = IN1_W'(i + 1);
         req_in2[i*IN2_W +: IN2_W] = 32'd3;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '0; rsp_ready = '0; spur = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({req_ready, rsp_valid, mult_start, mult_in1, mult_in2, rsp_result, busy, tag_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b rv=%b st=%b in1=%h in2=%h res=%h busy=%b err=%b exp all 0",
                  req_ready, rsp_valid, mult_start, mult_in1, mult_in2, rsp_result, busy, tag_err);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      test_reset(); set_ops();
      req_in1[2*IN1_W +: IN1_W] = 42'h1_0000_0001;
      req_in2[2*IN2_W +: IN2_W] = 32'h4000_0000;
      req_valid = 4'b0100; #1;
      checks++;
      if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready); end
      @(negedge clk); req_valid = '0; #1;
      checks++;
      if (mult_start !== 1'b1 || mult_in1 !== 42'h1_0000_0001 || mult_in2 !== 32'h4000_0000) begin
         errors++; $display("FAIL single_issue got st=%b in1=%h in2=%h exp 1 10000000001 40000000", mult_start, mult_in1, mult_in2);
      end
      for (int c = 2; c <= 6; c++) begin
         @(negedge clk); #1;
         checks++;
         if (c < 6 && rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp cyc %0d got %b exp 0000", c, rsp_valid); end
         if (c == 6 && (rsp_valid !== 4'b0100 || rsp_result !== 76'h4000_0000_4000_0000)) begin
            errors++; $display("FAIL single_rsp got %b %h exp 0100 4000000040000000", rsp_valid, rsp_result);
         end
         if (c == 3) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
         end
      end
      rsp_ready = 4'hF;
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_pop got rv=%b busy=%b exp 0000 0", rsp_valid, busy); end
   endtask

   task automatic test_fairness();
      test_reset(); set_ops();
      rsp_ready = 4'hF; req_valid = 4'hF;
      for (int k = 0; k < 23; k++) begin
         if (k == 16) req_valid = '0;
         #1;
         checks++;
         if (req_ready !== ((k < 16) ? 4'(1 << (k % 4)) : 4'b0000)) begin
            errors++; $display("FAIL fair_grant cyc %0d got %b exp %b", k, req_ready, (k < 16) ? 4'(1 << (k % 4)) : 4'b0000);
         end
         checks++;
         if (k >= 6 && k < 22) begin
            if (rsp_valid !== 4'(1 << ((k - 6) % 4)) || rsp_result !== RES_W'(3 * (((k - 6) % 4) + 1))) begin
               errors++; $display("FAIL fair_rsp cyc %0d got %b %0d exp %b %0d", k, rsp_valid, rsp_result,
                                  4'(1 << ((k - 6) % 4)), 3 * (((k - 6) % 4) + 1));
            end
         end else if (rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL fair_rsp_idle cyc %0d got %b exp 0000", k, rsp_valid);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_pressure();
      int n = 0, w = 0;
      test_reset(); set_ops();
      req_valid = 4'hF;
      for (int k = 0; k < 20; k++) begin
         #1; if (req_ready !== 4'b0000) n++;
         @(negedge clk);
      end
      checks++;
      if (n != 8) begin errors++; $display("FAIL bp_grant_count got %0d exp 8", n); end
      rsp_ready = 4'hF; #1;
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 4'b0001 || rsp_result !== 76'd3) begin
         errors++; $display("FAIL bp_full got rdy=%b rv=%b res=%0d exp 0000 0001 3", req_ready, rsp_valid, rsp_result);
      end
      @(negedge clk); #1;
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_regrant0 got %b exp 0001", req_ready); end
      @(negedge clk); #1;
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_regrant1 got %b exp 0010", req_ready); end
      @(negedge clk); req_valid = '0; #1;
      while (busy !== 1'b0 && w < 40) begin @(negedge clk); #1; w++; end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL bp_drain got busy=%b exp 0", busy); end
   endtask

   task automatic test_push_pop();
      test_reset(); set_ops();
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) req_valid = '0;
         @(negedge clk);
      end
      rsp_ready = 4'b0001; #1;
      checks++;
      if (rsp_valid !== 4'b0001 || mult_done !== 1'b1) begin
         errors++; $display("FAIL pp_setup got rv=%b done=%b exp 0001 1", rsp_valid, mult_done);
      end
      @(negedge clk); rsp_ready = 4'hF; #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL pp_busy got %b exp 1", busy); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rsp_valid !== ((k < 3) ? 4'(2 << k) : 4'b0000)) begin
            errors++; $display("FAIL pp_order idx %0d got %b exp %b", k, rsp_valid, (k < 3) ? 4'(2 << k) : 4'b0000);
         end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_spurious();
      test_reset();
      #1;
      checks++;
      if (tag_err !== 1'b0) begin errors++; $display("FAIL spur_pre got %b exp 0", tag_err); end
      spur = 1'b1;
      @(negedge clk); spur = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (tag_err !== 1'b1 || rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL spur_sticky cyc %0d got err=%b rv=%b busy=%b exp 1 0000 0", k, tag_err, rsp_valid, busy);
         end
         @(negedge clk);
      end
      rst_n = 1'b0; #1;
      checks++;
      if (tag_err !== 1'b0) begin errors++; $display("FAIL spur_clear got %b exp 0", tag_err); end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      test_reset(); set_ops();
      req_valid = 4'b0010;
      @(negedge clk); req_valid = '0;
      @(negedge clk); rst_n = 1'b0; #1;
      checks++;
      if ({req_ready, rsp_valid, mult_start, mult_in1, mult_in2, rsp_result, busy, tag_err} !== '0) begin
         errors++; $display("FAIL mid_async got st=%b in1=%h in2=%h busy=%b exp all 0", mult_start, mult_in1, mult_in2, busy);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0 || tag_err !== 1'b0) begin errors++; $display("FAIL mid_release got busy=%b err=%b exp 0 0", busy, tag_err); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         if (rsp_valid !== 4'b0000 || busy !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0 || tag_err !== 1'b1) begin errors++; $display("FAIL mid_late_done got stray=%0d err=%b exp 0 1", seen, tag_err); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_back_pressure();
      test_push_pop();
      test_spurious();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end
endmodule
